// File: rtl/load_unit_param.sv
// load_unit_param: multi-cycle RISC-V load unit (IDLE->ADDR->MEM->WB) with internal x-regs and byte memory.
// Optional macro LOAD_MISALIGN_SPLIT_EN: misaligned loads run as two aligned accesses instead of faulting.
module load_unit_param #(
  parameter  int XLEN      = 64,
  parameter  int NREGS     = 32,
  parameter  int MEM_BYTES = 256,
  parameter  int MEM_LAT   = 1,
  localparam int IW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IW-1:0]   rs1_idx,
  input  logic [IW-1:0]   rd_idx,
  input  logic [XLEN-1:0] offset,
  input  logic [2:0]      funct3,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] rdata,
  output logic            misaligned,
  output logic            illegal
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_MEM = 2'd2, S_WB = 2'd3;
`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic [1:0]      r_state;
  logic [IW-1:0]   r_rs1, r_rd;
  logic [XLEN-1:0] r_off;
  logic [2:0]      r_f3;
  logic [CW-1:0]   r_cnt;
  logic            r_second;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_regs [NREGS];

  // Data memory image has no write port on this unit: byte i holds i mod 256.
  logic [7:0] w_mem [MEM_BYTES];
  for (genvar g = 0; g < MEM_BYTES; g++) begin : g_mem
    assign w_mem[g] = 8'(g);
  end

  logic [3:0]        w_sz;
  logic [2:0]        w_boff;
  logic              w_ill, w_mis, w_fault, w_last;
  logic [XLEN-1:0]   w_base, w_fa, w_fetch, w_mask, w_raw, w_ext;
  logic [2*XLEN-1:0] w_merged;

  always_comb begin
    w_sz    = 4'd1 << r_f3[1:0];
    w_ill   = (r_f3 == 3'b111) || (XLEN == 32 && (r_f3 == 3'b011 || r_f3 == 3'b110));
    w_boff  = addr[2:0] & 3'(w_sz - 4'd1);
    w_mis   = !w_ill && (w_boff != 3'd0);
    w_fault = w_ill || (w_mis && !SPLIT);
    w_last  = (r_cnt == CW'(MEM_LAT - 1));
    w_base  = addr & ~XLEN'(w_sz - 4'd1);
    // Second pass of a split access fetches the next aligned chunk.
    w_fa    = r_second ? w_base + XLEN'(w_sz) : w_base;
    w_fetch = '0;
    for (int k = 0; k < XLEN/8; k++)
      w_fetch[k*8 +: 8] = w_mem[AW'(w_fa) + AW'(k)];
    w_mask   = (w_sz >= 4'(XLEN/8)) ? '1 : ((XLEN'(1) << (w_sz * 8)) - XLEN'(1));
    w_merged = {{XLEN{1'b0}}, r_lo & w_mask} | ({{XLEN{1'b0}}, w_fetch & w_mask} << (w_sz * 8));
    w_raw    = (r_second ? XLEN'(w_merged >> (w_boff * 8)) : w_fetch) & w_mask;
    w_ext    = (!r_f3[2] && w_raw[w_sz*8-1]) ? (w_raw | ~w_mask) : w_raw;
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      done       <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      rs1_val    <= '0;
      addr       <= '0;
      rdata      <= '0;
      r_rs1      <= '0;
      r_rd       <= '0;
      r_off      <= '0;
      r_f3       <= '0;
      r_cnt      <= '0;
      r_second   <= 1'b0;
      r_lo       <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= XLEN'(8 * i);
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_rs1   <= rs1_idx;
          r_rd    <= rd_idx;
          r_off   <= offset;
          r_f3    <= funct3;
          r_state <= S_ADDR;
        end
        S_ADDR: begin
          rs1_val  <= r_regs[r_rs1];
          addr     <= r_regs[r_rs1] + r_off;
          r_cnt    <= '0;
          r_second <= 1'b0;
          r_state  <= S_MEM;
        end
        S_MEM: begin
          if (!w_last) r_cnt <= r_cnt + 1'b1;
          else if (SPLIT && w_mis && !r_second) begin
            r_lo     <= w_fetch;
            r_second <= 1'b1;
            r_cnt    <= '0;
          end else begin
            rdata   <= w_fault ? '0 : w_ext;
            r_state <= S_WB;
          end
        end
        default: begin
          done       <= 1'b1;
          illegal    <= w_ill;
          misaligned <= w_mis && !SPLIT;
          if (!w_fault && r_rd != '0) r_regs[r_rd] <= rdata;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_unit_param.sv
// tb_load_unit_param: directed self-checking bench for load_unit_param (XLEN=64, MEM_LAT=1).
module tb_load_unit_param;
  localparam int MEM_LAT = 1;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LD = 3'b011,
                         LBU = 3'b100, LHU = 3'b101, LWU = 3'b110, BAD = 3'b111;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [4:0]  rs1_idx = '0, rd_idx = '0;
  logic [63:0] offset = '0;
  logic [2:0]  funct3 = '0;
  logic        busy, done, misaligned, illegal;
  logic [63:0] rs1_val, addr, rdata;

  int checks = 0, errors = 0;
  int lat;
  logic        c_busy1, c_mis, c_ill;
  logic [63:0] c_rdata, c_addr, c_rs1v;

  load_unit_param #(.XLEN(64), .NREGS(32), .MEM_BYTES(256), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .rs1_idx(rs1_idx), .rd_idx(rd_idx),
    .offset(offset), .funct3(funct3), .busy(busy), .done(done), .rs1_val(rs1_val),
    .addr(addr), .rdata(rdata), .misaligned(misaligned), .illegal(illegal));

  always #5 clk = ~clk;

  // Issue one command and wait (bounded) for done; capture outputs in the done cycle.
  task automatic run_load(input logic [4:0] rs1, input logic [4:0] rd, input logic [63:0] off,
                          input logic [2:0] f3);
    @(negedge clk);
    start = 1'b1; rs1_idx = rs1; rd_idx = rd; offset = off; funct3 = f3;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) c_busy1 = busy;
      if (done) begin
        lat = k; c_rdata = rdata; c_addr = addr; c_rs1v = rs1_val;
        c_mis = misaligned; c_ill = illegal;
        break;
      end
    end
    checks++;
    if (lat < 0) begin errors++; $display("FAIL timeout: no done within 40 cycles (rs1=%0d f3=%0d)", rs1, f3); end
  endtask

  // Register contents are observed through rs1_val of a non-writing probe load.
  task automatic probe_reg(input logic [4:0] r, input logic [63:0] exp, input string nm);
    run_load(r, 5'd0, 64'd0, LBU);
    checks++;
    if (c_rs1v !== exp) begin errors++; $display("FAIL %s: got %h expected %h", nm, c_rs1v, exp); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, misaligned, illegal} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, misaligned, illegal});
    end
    checks++;
    if ({rs1_val, addr, rdata} !== 192'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h expected zeros", rs1_val, addr, rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    run_load(5'd2, 5'd7, 64'd6, LBU);
    checks++;
    if (lat !== 3 + MEM_LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, 3 + MEM_LAT); end
    checks++;
    if (c_busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", c_busy1); end
    checks++;
    if (c_rs1v !== 64'd16 || c_addr !== 64'd22) begin
      errors++; $display("FAIL basic_addr: got rs1_val=%0d addr=%0d expected 16/22", c_rs1v, c_addr);
    end
    checks++;
    if (c_rdata !== 64'h16 || c_mis !== 1'b0 || c_ill !== 1'b0) begin
      errors++; $display("FAIL basic_rdata: got %h mis=%b ill=%b expected 16/0/0", c_rdata, c_mis, c_ill);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done); end
    probe_reg(5'd7, 64'h16, "x7_writeback");
  endtask

  task automatic test_sign_ext;
    logic [2:0]  f3s [6] = '{LB, LBU, LH, LHU, LW, LWU};
    logic [63:0] exps [6] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'hFFFFFFFFFFFF8988, 64'h8988,
                              64'hFFFFFFFF8B8A8988, 64'h8B8A8988};
    for (int i = 0; i < 6; i++) begin
      run_load(5'd16, 5'd0, 64'd8, f3s[i]);
      checks++;
      if (c_addr !== 64'd136 || c_rdata !== exps[i]) begin
        errors++; $display("FAIL sign_ext[%0d]: got addr=%0d rdata=%h expected 136/%h", i, c_addr, c_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_wb_wrap;
    run_load(5'd3, 5'd5, 64'd0, LD);
    checks++;
    if (c_rdata !== 64'h1F1E1D1C1B1A1918) begin errors++; $display("FAIL ld_x3: got %h expected 1f1e1d1c1b1a1918", c_rdata); end
    run_load(5'd5, 5'd0, 64'd0, LW);
    checks++;
    if (c_rs1v !== 64'h1F1E1D1C1B1A1918 || c_addr !== 64'h1F1E1D1C1B1A1918) begin
      errors++; $display("FAIL wb_visible: got rs1_val=%h addr=%h expected 1f1e1d1c1b1a1918", c_rs1v, c_addr);
    end
    checks++;
    if (c_rdata !== 64'h1B1A1918) begin errors++; $display("FAIL addr_wrap_lw: got %h expected 1b1a1918", c_rdata); end
    run_load(5'd2, 5'd0, 64'hFFFFFFFFFFFFFFEF, LBU);
    checks++;
    if (c_addr !== 64'hFFFFFFFFFFFFFFFF || c_rdata !== 64'hFF) begin
      errors++; $display("FAIL neg_offset: got addr=%h rdata=%h expected ffffffffffffffff/ff", c_addr, c_rdata);
    end
  endtask

  task automatic test_misaligned;
    run_load(5'd2, 5'd9, 64'd6, LW);
    checks++;
    if (c_addr !== 64'd22) begin errors++; $display("FAIL mis_addr: got %0d expected 22", c_addr); end
`ifdef LOAD_MISALIGN_SPLIT_EN
    checks++;
    if (lat !== 3 + 2 * MEM_LAT || c_mis !== 1'b0 || c_rdata !== 64'h19181716) begin
      errors++; $display("FAIL split_lw: got lat=%0d mis=%b rdata=%h expected %0d/0/19181716", lat, c_mis, c_rdata, 3 + 2 * MEM_LAT);
    end
    probe_reg(5'd9, 64'h19181716, "x9_split");
    run_load(5'd31, 5'd0, 64'd4, LD);
    checks++;
    if (c_mis !== 1'b0 || c_rdata !== 64'h03020100FFFEFDFC) begin
      errors++; $display("FAIL split_ld_wrap: got mis=%b rdata=%h expected 0/03020100fffefdfc", c_mis, c_rdata);
    end
`else
    checks++;
    if (lat !== 3 + MEM_LAT || c_mis !== 1'b1 || c_rdata !== 64'd0) begin
      errors++; $display("FAIL mis_lw: got lat=%0d mis=%b rdata=%h expected %0d/1/0", lat, c_mis, c_rdata, 3 + MEM_LAT);
    end
    probe_reg(5'd9, 64'd72, "x9_unchanged");
    run_load(5'd31, 5'd0, 64'd4, LD);
    checks++;
    if (c_mis !== 1'b1 || c_rdata !== 64'd0) begin
      errors++; $display("FAIL mis_ld: got mis=%b rdata=%h expected 1/0", c_mis, c_rdata);
    end
`endif
  endtask

  task automatic test_illegal_x0;
    run_load(5'd1, 5'd10, 64'd0, BAD);
    checks++;
    if (c_ill !== 1'b1 || c_rdata !== 64'd0 || c_mis !== 1'b0) begin
      errors++; $display("FAIL illegal: got ill=%b rdata=%h mis=%b expected 1/0/0", c_ill, c_rdata, c_mis);
    end
    probe_reg(5'd10, 64'd80, "x10_no_write");
    run_load(5'd3, 5'd0, 64'd0, LD);
    probe_reg(5'd0, 64'd0, "x0_zero");
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    logic [63:0] d_rdata = '0;
    @(negedge clk);
    start = 1'b1; rs1_idx = 5'd2; rd_idx = 5'd12; offset = 64'd6; funct3 = LBU;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      // Keep strobing a different LD command while the first is in flight.
      if (k == 1) begin rs1_idx = 5'd3; offset = 64'd0; funct3 = LD; end
      if (k == 3) start = 1'b0;
      if (done) begin ndone++; d_rdata = rdata; end
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL busy_ignore_count: got %0d dones expected 1", ndone); end
    checks++;
    if (d_rdata !== 64'h16) begin errors++; $display("FAIL busy_ignore_data: got %h expected 16", d_rdata); end
    probe_reg(5'd12, 64'h16, "x12_first_cmd");
  endtask

  task automatic test_reset_abort;
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; rs1_idx = 5'd3; rd_idx = 5'd4; offset = 64'd0; funct3 = LD;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state: got busy=%b done=%b expected 0/0", busy, done); end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL abort_done: got %0d dones expected 0", ndone); end
    probe_reg(5'd4, 64'd32, "x4_after_abort");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sign_ext;
    test_wb_wrap;
    test_misaligned;
    test_illegal_x0;
    test_back_to_back;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_unit_param.md
Name: load_unit_param

Overview:
- Parametrised multi-cycle RISC-V load unit.
- Contains an internal integer register file and a byte-addressable little-endian data memory.
- Executes one load per command: effective address = x[rs1] + offset; size/sign selected by funct3; write-back to x[rd].
- Next generation of the single-width load datapath: adds all load widths, sign/zero extension, a start/done handshake and misalignment handling.

Parameters:
- XLEN, 64, register and data width (32 or 64).
- NREGS, 32, register count; index width is clog2(NREGS).
- MEM_BYTES, 256, data memory size in bytes; power of two.
- MEM_LAT, 1, memory read latency in cycles (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- rs1_idx  in  clog2(NREGS)  base register index.
- rd_idx  in  clog2(NREGS)  destination register index.
- offset  in  XLEN  signed offset.
- funct3  in  3  load type.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- rs1_val  out  XLEN  latched x[rs1].
- addr  out  XLEN  latched effective address.
- rdata  out  XLEN  extended load result.
- misaligned  out  1  valid with done.
- illegal  out  1  valid with done.

Behaviour:
- Reset: state IDLE; busy, done, misaligned, illegal = 0; rs1_val, addr, rdata = 0; x[i] = 8*i for all i (x0 = 0).
- Memory is not reset. Simulation initialises byte[i] = i mod 256.
- Memory index is addr mod MEM_BYTES; address wrap-around is silent.
- States: IDLE -> ADDR -> MEM -> WB -> IDLE.
- IDLE: start=1 at edge E latches rs1_idx, rd_idx, offset, funct3; go to ADDR.
- ADDR: at the next edge, rs1_val <= x[rs1]; addr <= x[rs1] + offset (mod 2^XLEN); go to MEM.
- MEM: stays MEM_LAT cycles; rdata is registered on the last edge; go to WB.
- WB: done=1 for exactly one cycle. If the load is neither illegal nor misaligned and rd != 0, x[rd] <= rdata at the WB edge. Then IDLE.
- Latency: done is high in the cycle after edge E+2+MEM_LAT.
- funct3 decode:
  - 000 LB, 001 LH, 010 LW, 011 LD: sign-extend.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - 111: illegal.
  - XLEN=32: 011 and 110 are also illegal.
- Illegal load: illegal=1 with done; rdata=0; no write.
- Misaligned load: addr mod size != 0. Handling is defined under Optional Feature.
- start while busy is ignored; there is no queueing.
- reset during any state aborts to IDLE; no register write occurs; the reset values above apply.
- Writes to x0 are discarded; x0 always reads 0.
- A write-back is visible to the next command's ADDR state; no bypass is needed.

Optional Feature:
- Macro LOAD_MISALIGN_SPLIT_EN.
- Defined:
  - A misaligned load is executed as two aligned accesses: the MEM state runs twice, adding MEM_LAT cycles.
  - Bytes are merged little-endian, with wrap at MEM_BYTES.
  - Result and write-back are correct; misaligned=0.
- Undefined:
  - A misaligned load completes with normal latency, misaligned=1, rdata=0, no register write.

Test Plan:
- Reset, then rs1=2 (x2=16), offset=6, LBU, rd=7 -> addr=22, rdata=0x16, x7=0x16; done exactly 3+MEM_LAT cycles after start.
- rs1=16 (x16=128), offset=8, LB -> addr=136, rdata=0xFFFFFFFFFFFFFF88; same with LBU -> rdata=0x88.
- rs1=3, offset=0, LD, rd=5 -> rdata=0x1F1E1D1C1B1A1918. Then rs1=5, offset=0, LW -> index 0x18, rdata=0x000000001B1A1918 (checks write-back and address wrap).
- rs1=2, offset=6, LW, rd=9 -> addr=22:
  - Macro undefined: misaligned=1, x9 unchanged (72).
  - Macro defined: rdata=0x0000000019181716, x9 updated, done one MEM_LAT later.
- funct3=111 -> illegal=1, no write. LD with rd=0 -> x0 stays 0. start pulsed while busy -> ignored, exactly one done.
- Assert reset in MEM state of an LD to rd=4 -> no done, x4=32, busy=0 next cycle.
